// File: rtl/keyb_event_fifo.sv
// rtl/keyb_event_fifo.sv - debounced keypad event generator feeding a small key FIFO
//
// Purpose:
//   Takes the keypad scanner's held code and pressed flag, debounces presses and
//   releases, decodes each accepted press into a 4-bit key value and queues exactly
//   one event per physical press. Events drain through a valid/ready handshake.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   btn_pressed scanner pressed flag
//   btn_code    scanner code, [7:4] column one-hot, [3:0] row one-hot
//   key_data    FIFO head key value (registered)
//   key_valid   FIFO non-empty
//   key_ready   consumer accepts the head when key_valid and key_ready at a rising edge
//   overflow    one-cycle pulse when an event is dropped because the FIFO is full
//   fifo_count  current FIFO occupancy
//
// Optional feature:
//   KEYB_HEX_MAP_EN - when defined, the raw row*4+col index is remapped to the
//   printed keypad legend before it is queued.

module keyb_event_fifo #(
    parameter int DEB_CYCLES = 16,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_pressed,
    input  logic [7:0]               btn_code,
    output logic [3:0]               key_data,
    output logic                     key_valid,
    input  logic                     key_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [7:0]      DEB_C   = 8'(DEB_CYCLES);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Code qualification and decode
    // ------------------------------------------------------------------
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[3])      idx = 2'd3;
        else if (v[2]) idx = 2'd2;
        else if (v[1]) idx = 2'd1;
        return idx;
    endfunction

    function automatic logic [3:0] map_key(input logic [3:0] idx);
`ifdef KEYB_HEX_MAP_EN
        logic [3:0] val;
        case (idx)
            4'd0:    val = 4'h1;
            4'd1:    val = 4'h2;
            4'd2:    val = 4'h3;
            4'd3:    val = 4'hA;
            4'd4:    val = 4'h4;
            4'd5:    val = 4'h5;
            4'd6:    val = 4'h6;
            4'd7:    val = 4'hB;
            4'd8:    val = 4'h7;
            4'd9:    val = 4'h8;
            4'd10:   val = 4'h9;
            4'd11:   val = 4'hC;
            4'd12:   val = 4'hE;
            4'd13:   val = 4'h0;
            4'd14:   val = 4'hF;
            default: val = 4'hD;
        endcase
        return val;
`else
        return idx;
`endif
    endfunction

    logic       code_valid;
    logic [3:0] push_data;

    assign code_valid = btn_pressed && is_onehot4(btn_code[7:4]) && is_onehot4(btn_code[3:0]);

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] cand, cand_n;
    logic [7:0] cnt_inc;
    logic       push;

    assign cnt_inc = cnt + 8'd1;

    // The candidate equals btn_code on the push edge, so decoding the latched
    // candidate keeps the pushed value independent of same-cycle input changes.
    assign push_data = map_key({enc4(cand[3:0]), enc4(cand[7:4])});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            cand  <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (code_valid) begin
                    cand_n  = btn_code;
                    cnt_n   = 8'd1;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (code_valid && (btn_code == cand)) begin
                    if (cnt_inc == DEB_C) begin
                        push    = 1'b1;
                        cnt_n   = 8'd0;
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else begin
                    cnt_n   = 8'd0;
                    state_n = IDLE;
                end
            end
            HELD: begin
                // Any code is tolerated while held: rolling onto a second key
                // must not create a new event.
                if (!btn_pressed) begin
                    cnt_n   = 8'd1;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (btn_pressed) begin
                    cnt_n   = 8'd0;
                    state_n = HELD;
                end else if (cnt_inc == DEB_C) begin
                    cnt_n   = 8'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                cnt_n   = 8'd0;
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] rd_ptr_inc;
    logic          pop, full, wr_en, drop;
    logic [CW-1:0] count_n;
    logic [3:0]    head_n;

    assign pop        = key_valid && key_ready;
    assign full       = (fifo_count == DEPTH_C);
    assign wr_en      = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    always_comb begin
        count_n = fifo_count;
        if (wr_en && !pop)      count_n = fifo_count + ONE_C;
        else if (!wr_en && pop) count_n = fifo_count - ONE_C;
    end

    // key_data is kept as its own register holding the next head, so the output
    // never glitches through the storage read mux.
    always_comb begin
        head_n = key_data;
        if (fifo_count == '0) begin
            if (wr_en) head_n = push_data;
        end else if (pop) begin
            if (fifo_count == ONE_C) begin
                if (wr_en) head_n = push_data;
            end else begin
                head_n = mem[rd_ptr_inc];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            key_valid  <= 1'b0;
            key_data   <= 4'd0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr_inc;
            fifo_count <= count_n;
            key_valid  <= (count_n != '0);
            key_data   <= head_n;
            overflow   <= drop;
        end
    end

endmodule

// File: doc/keyb_event_fifo.md
Name: keyb_event_fifo

Overview:
- Sits directly downstream of the keypad scanner.
- Consumes the scanner's held key code (column one-hot in [7:4], row one-hot in [3:0]) and its pressed flag.
- Debounces the code, decodes it to a 4-bit key index, and emits exactly one event per physical press into a small FIFO.
- The FIFO drains through a valid/ready handshake to the application logic (display, calculator core).

Parameters:
- DEB_CYCLES, 16: consecutive clocks a code (press) or absence (release) must be stable before it is accepted; legal range 2..255.
- DEPTH, 4: FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_pressed  input  1  scanner pressed flag
- btn_code  input  8  scanner code; [7:4] column one-hot, [3:0] row one-hot
- key_data  output  4  FIFO head key index
- key_valid  output  1  FIFO non-empty
- key_ready  input  1  consumer accepts head when key_valid and key_ready at a rising edge
- overflow  output  1  one-cycle pulse when an event is dropped on a full FIFO
- fifo_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE; debounce counter and candidate are cleared; FIFO is emptied.
  - key_data=0, key_valid=0, overflow=0, fifo_count=0.
  - Reset asserted mid-debounce or while the FIFO is non-empty discards everything.
- Valid code: btn_pressed=1, and btn_code[7:4] and btn_code[3:0] each have exactly one bit set. Anything else while btn_pressed=1 (ghosting, multi-key) is invalid.
- Decode: c = column bit index, r = row bit index; key index = {r[1:0], c[1:0]} (r*4+c).
- FSM states IDLE, DEBOUNCE, HELD, RELEASE:
  - IDLE: on a valid code, latch candidate=btn_code, cnt=1, go to DEBOUNCE. Otherwise stay.
  - DEBOUNCE: if btn_code == candidate and valid, cnt++. On the edge where cnt reaches DEB_CYCLES, push the decoded key and go to HELD. On any mismatch or invalid input, go to IDLE without pushing.
  - HELD: stay while btn_pressed=1, whatever the code (rollover to a second key produces no event). On btn_pressed=0, cnt=1 and go to RELEASE.
  - RELEASE: btn_pressed=0 increments cnt; reaching DEB_CYCLES goes to IDLE. Any btn_pressed=1 returns to HELD with no new event (bounce on release).
- Event-to-output timing: the push happens at the clock edge where the count completes. key_valid rises on that same edge if the FIFO was empty, so it is visible in the following cycle. key_data is registered from the head entry.
- Minimum press-to-event latency is DEB_CYCLES clocks after the first valid sample.
- FIFO:
  - Pop occurs when key_valid and key_ready are both high.
  - Full with a push and no pop: the event is dropped and overflow pulses high for exactly one cycle.
  - Full with a push and a pop in the same cycle: both succeed and the count is unchanged.
  - Empty with a push: the pushed entry appears as head next cycle; a pop is impossible that cycle.
  - Pointers wrap modulo DEPTH. fifo_count is exact and never exceeds DEPTH.
- key_ready while key_valid=0 is ignored. key_data holds its value while key_valid=1 and key_ready=0.

Optional Feature:
- Macro: KEYB_HEX_MAP_EN.
- Defined: the key index is remapped before the push to the 4x4 keypad legend. Row 0 = 1,2,3,A; row 1 = 4,5,6,B; row 2 = 7,8,9,C; row 3 = E(*),0,F(#),D. Values are pushed as 4'h1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D for index 0..15.
- Undefined: the raw r*4+c index is pushed.
- All other behaviour is identical in both cases.

Test Plan:
All scenarios use DEB_CYCLES=4 and DEPTH=4; the macro is undefined unless stated.
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0. Release, then btn_code=8'h21 with btn_pressed=1 for 4 clocks -> key_valid=1, key_data=4'h1 (r0,c1), fifo_count=1.
- Bounce: btn_code=8'h44 for 2 clocks, then 8'h00/btn_pressed=0 for 1 clock, then 8'h44 for 4 clocks -> exactly one event, key_data=4'hA. Toggling btn_pressed 1-0-1 during RELEASE with short gaps -> no second event.
- Ghosting: btn_code=8'h33 (two columns) held 20 clocks -> no event, FSM stays IDLE, key_valid=0.
- Overflow: with key_ready=0, do 5 full press/release cycles on distinct keys -> fifo_count=4, one overflow pulse on the 5th push, and the FIFO holds the first four keys in order.
- Simultaneous push/pop: with the FIFO full and key_ready=1 on the push edge -> no overflow, fifo_count stays 4, head advances to the 2nd key.
- Map: KEYB_HEX_MAP_EN defined, press btn_code=8'h28 (c1,r3) -> key_data=4'h0; press 8'h18 (c0,r3) -> 4'hE.
